palette_pixel_source: RTL and testbench

- Producer end of the LCD pixel-writer handshake (rgb / invalidData / rgbRequest), in the palette pipe stage.
- Accepts 8-bit palette indices from the upstream pipe into a small FIFO.
- Expands each index to 24-bit RGB through a writable 256-entry palette.
- Presents one pixel at a time to the LCD writer; signals frame completion and underruns.

---
 rtl/gpu_pipe_pkg.sv | 35 +++
 rtl/index_fifo.sv | 69 ++++++
 rtl/palette_pixel_source.sv | 121 ++++++++++++
 tb/tb_palette_pixel_source.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pipe_pkg.sv
// Types and constants shared by the palette stage and the LCD pixel writer.
package gpu_pipe_pkg;

    localparam int unsigned RGB_W       = 24;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned PAL_ENTRIES = 256;
    localparam int unsigned HOR_PIX_DEF = 480;
    localparam int unsigned VER_PIX_DEF = 272;
    localparam int unsigned PIX_CNT_W   = 19;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned R_LSB = 2 * CH_W;
    localparam int unsigned G_LSB = CH_W;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic rgb_t unpack_rgb(input logic [RGB_W-1:0] w);
        rgb_t p;
        p.r = w[R_LSB +: CH_W];
        p.g = w[G_LSB +: CH_W];
        p.b = w[B_LSB +: CH_W];
        return p;
    endfunction

endpackage

// File: rtl/index_fifo.sv
// Synchronous index FIFO with occupancy count and synchronous flush.
module index_fifo
    import gpu_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [IDX_W-1:0] data_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/palette_pixel_source.sv
// Palette stage: buffers indices, expands them through a writable palette and
// feeds the LCD writer one pixel at a time via rgb/invalidData/rgbRequest.
module palette_pixel_source
    import gpu_pipe_pkg::*;
#(
    parameter int unsigned HOR_PIX    = HOR_PIX_DEF,
    parameter int unsigned VER_PIX    = VER_PIX_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic               clk_12mhz,
    input  logic               rst,
    input  logic               idx_valid,
    input  logic [IDX_W-1:0]   idx_data,
    output logic               idx_ready,
    input  logic               pal_we,
    input  logic [IDX_W-1:0]   pal_addr,
    input  logic [RGB_W-1:0]   pal_wdata,
    input  logic               flush,
    input  logic               clear_status,
    input  logic               rgbRequest,
    output logic [RGB_W-1:0]   rgb,
    output logic               invalidData,
    output logic               frame_done,
    output logic               underrun,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(HOR_PIX * VER_PIX - 1);

    rgb_t                 pal_q [PAL_ENTRIES];
    out_state_e           state_q, state_d;
    rgb_t                 rgb_q, rgb_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 underrun_q, underrun_d;

    logic [IDX_W-1:0]     fifo_head;
    logic                 fifo_full, fifo_empty;
    logic                 fifo_push, fifo_pop;
    logic                 consume, load;

    index_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_12mhz),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (fifo_push),
        .data_i  (idx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign idx_ready   = !fifo_full;
    assign fifo_push   = idx_valid && !fifo_full;
    assign fifo_pop    = load;
    assign rgb         = rgb_q;
    assign invalidData = (state_q == OUT_EMPTY);
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;

    always_comb begin
        state_d      = state_q;
        rgb_d        = rgb_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;
        consume      = rgbRequest && (state_q == OUT_FULL);
        load         = ((state_q == OUT_EMPTY) || consume) && !fifo_empty && !flush;

        // A request against an empty output stage outranks a status clear.
        if (rgbRequest && (state_q == OUT_EMPTY)) underrun_d = 1'b1;
        else if (clear_status)                    underrun_d = 1'b0;

        if (flush) begin
            state_d   = OUT_EMPTY;
            pix_cnt_d = '0;
        end else begin
            if (load) begin
                state_d = OUT_FULL;
                rgb_d   = pal_q[fifo_head];
            end else if (consume) begin
                state_d = OUT_EMPTY;
            end
            if (consume) begin
                if (pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            state_q      <= OUT_EMPTY;
            rgb_q        <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rgb_q        <= rgb_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (pal_we) pal_q[pal_addr] <= unpack_rgb(pal_wdata);
    end

endmodule

// File: tb/tb_palette_pixel_source.sv
// Bench for palette_pixel_source with a queue-based reference model; frame
// size is shrunk to 8x4 so frame wrap is reachable quickly.
module tb_palette_pixel_source;

    localparam int HP    = 8;
    localparam int VP    = 4;
    localparam int FRAME = HP * VP;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        idx_valid = 1'b0;
    logic [7:0]  idx_data = '0;
    logic        idx_ready;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_wdata = '0;
    logic        flush = 1'b0;
    logic        clear_status = 1'b0;
    logic        rgbRequest = 1'b0;
    logic [23:0] rgb;
    logic        invalidData;
    logic        frame_done;
    logic        underrun;
    logic [4:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          mq[$];
    bit          m_valid = 0;
    logic [23:0] m_rgb = '0;
    int          m_cnt = 0;
    bit          m_fd = 0;
    bit          m_ur = 0;
    logic [23:0] m_pal [256];

    palette_pixel_source #(
        .HOR_PIX    (HP),
        .VER_PIX    (VP),
        .FIFO_DEPTH (16),
        .FIFO_AW    (4)
    ) dut (
        .clk_12mhz    (clk),
        .rst          (rst),
        .idx_valid    (idx_valid),
        .idx_data     (idx_data),
        .idx_ready    (idx_ready),
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_wdata    (pal_wdata),
        .flush        (flush),
        .clear_status (clear_status),
        .rgbRequest   (rgbRequest),
        .rgb          (rgb),
        .invalidData  (invalidData),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_valid = 0;
        m_rgb   = '0;
        m_cnt   = 0;
        m_fd    = 0;
        m_ur    = 0;
    endtask

    // One clock edge; the model applies the behavioural rules to the inputs held across it.
    task automatic tick();
        int qsz;
        bit cons;
        bit ev;
        @(posedge clk);
        qsz  = mq.size();
        cons = rgbRequest && m_valid;
        ev   = rgbRequest && !m_valid;
        if (flush) begin
            mq.delete();
            m_valid = 0;
            m_cnt   = 0;
            m_fd    = 0;
        end else begin
            m_fd = 0;
            if (cons) begin
                if (m_cnt == FRAME - 1) begin
                    m_cnt = 0;
                    m_fd  = 1;
                end else begin
                    m_cnt++;
                end
            end
            if ((!m_valid || cons) && qsz > 0) begin
                m_rgb   = m_pal[mq.pop_front()];
                m_valid = 1;
            end else if (cons) begin
                m_valid = 0;
            end
            if (idx_valid && qsz < DEPTH) mq.push_back(int'(idx_data));
        end
        if (ev) m_ur = 1;
        else if (clear_status) m_ur = 0;
        if (pal_we) m_pal[pal_addr] = pal_wdata;
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (idx_ready !== 1'b1) begin errors++; $display("FAIL reset_idx_ready: got %b expected 1", idx_ready); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", rgb); end
        if (invalidData !== 1'b1) begin errors++; $display("FAIL reset_invalid: got %b expected 1", invalidData); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        model_reset();
        rst = 1'b1;
        pal_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pal_addr  = 8'(i);
            pal_wdata = 24'($urandom);
            tick();
        end
        pal_we = 1'b0;
    endtask

    task automatic test_basic();
        pal_we = 1'b1; pal_addr = 8'd5; pal_wdata = 24'hFF8000;
        tick();
        pal_we = 1'b0;
        idx_valid = 1'b1; idx_data = 8'd5;
        tick();
        idx_valid = 1'b0;
        checks += 2;
        if (invalidData !== 1'b1) begin errors++; $display("FAIL basic_after_E_invalid: got %b expected 1", invalidData); end
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL basic_after_E_level: got %0d expected 1", fifo_level); end
        tick();
        checks += 3;
        if (rgb !== 24'hFF8000) begin errors++; $display("FAIL basic_rgb: got %h expected ff8000", rgb); end
        if (invalidData !== 1'b0) begin errors++; $display("FAIL basic_valid: got %b expected 0", invalidData); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL basic_level: got %0d expected 0", fifo_level); end
        rgbRequest = 1'b1;
        tick();
        rgbRequest = 1'b0;
        checks += 2;
        if (invalidData !== 1'b1) begin errors++; $display("FAIL basic_drain_invalid: got %b expected 1", invalidData); end
        if (rgb !== 24'hFF8000) begin errors++; $display("FAIL basic_drain_rgb_hold: got %h expected ff8000", rgb); end
    endtask

    task automatic test_fill();
        logic [7:0] a [18];
        for (int i = 0; i < 18; i++) a[i] = 8'($urandom);
        idx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            idx_data = a[i];
            tick();
        end
        checks += 3;
        if (idx_ready !== 1'b0) begin errors++; $display("FAIL fill_idx_ready: got %b expected 0", idx_ready); end
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d expected 16", fifo_level); end
        if (invalidData !== 1'b0) begin errors++; $display("FAIL fill_out_valid: got %b expected 0", invalidData); end
        idx_data = a[17];
        tick();
        idx_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_drop_level: got %0d expected 16", fifo_level); end
        rgbRequest = 1'b1;
        for (int j = 0; j < 17; j++) begin
            checks += 2;
            if (invalidData !== 1'b0) begin errors++; $display("FAIL fill_px%0d_valid: got %b expected 0", j, invalidData); end
            if (rgb !== m_pal[a[j]]) begin errors++; $display("FAIL fill_px%0d_rgb: got %h expected %h", j, rgb, m_pal[a[j]]); end
            tick();
        end
        rgbRequest = 1'b0;
        checks += 2;
        if (invalidData !== 1'b1) begin errors++; $display("FAIL fill_end_invalid: got %b expected 1", invalidData); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL fill_end_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_underrun();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_initial: got %b expected 0", underrun); end
        rgbRequest = 1'b1;
        tick();
        rgbRequest = 1'b0;
        tick(); tick();
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
        rgbRequest = 1'b1; clear_status = 1'b1;
        tick();
        rgbRequest = 1'b0; clear_status = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b expected 1", underrun); end
    endtask

    task automatic test_pal_rbw();
        pal_we = 1'b1; pal_addr = 8'd7; pal_wdata = 24'h0000FF;
        tick();
        pal_we = 1'b0;
        idx_valid = 1'b1; idx_data = 8'd7;
        tick();
        pal_we = 1'b1; pal_addr = 8'd7; pal_wdata = 24'h00FF00;
        tick();
        pal_we = 1'b0; idx_valid = 1'b0;
        checks += 2;
        if (rgb !== 24'h0000FF) begin errors++; $display("FAIL rbw_old: got %h expected 0000ff", rgb); end
        if (invalidData !== 1'b0) begin errors++; $display("FAIL rbw_valid: got %b expected 0", invalidData); end
        rgbRequest = 1'b1;
        tick();
        checks++;
        if (rgb !== 24'h00FF00) begin errors++; $display("FAIL rbw_new: got %h expected 00ff00", rgb); end
        tick();
        rgbRequest = 1'b0;
        checks++;
        if (invalidData !== 1'b1) begin errors++; $display("FAIL rbw_drain: got %b expected 1", invalidData); end
    endtask

    task automatic test_flush();
        idx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idx_data = 8'($urandom);
            tick();
        end
        checks += 2;
        if (fifo_level !== 5'd9) begin errors++; $display("FAIL flush_pre_level: got %0d expected 9", fifo_level); end
        if (invalidData !== 1'b0) begin errors++; $display("FAIL flush_pre_valid: got %b expected 0", invalidData); end
        flush = 1'b1; rgbRequest = 1'b1;
        tick();
        flush = 1'b0; rgbRequest = 1'b0; idx_valid = 1'b0;
        checks += 4;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", fifo_level); end
        if (invalidData !== 1'b1) begin errors++; $display("FAIL flush_invalid: got %b expected 1", invalidData); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL flush_frame_done: got %b expected 0", frame_done); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL flush_underrun_kept: got %b expected 1", underrun); end
    endtask

    // Runs straight after the flush, so the pixel counter starts from zero.
    task automatic test_frame();
        int n = 0;
        int pulses = 0;
        bit cons;
        bit exp_fd;
        idx_valid = 1'b1; rgbRequest = 1'b1;
        for (int c = 0; c < 75; c++) begin
            idx_data = 8'($urandom);
            cons = m_valid;
            if (cons) n++;
            exp_fd = cons && (n % FRAME == 0);
            tick();
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL frame_done_c%0d: got %b expected %b (consume %0d)", c, frame_done, exp_fd, n); end
            if (frame_done === 1'b1) pulses++;
        end
        idx_valid = 1'b0;
        tick(); tick(); tick();
        rgbRequest = 1'b0;
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL frame_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_async_reset();
        idx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idx_data = 8'($urandom);
            tick();
        end
        idx_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks += 5;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL arst_level: got %0d expected 0", fifo_level); end
        if (idx_ready !== 1'b1) begin errors++; $display("FAIL arst_idx_ready: got %b expected 1", idx_ready); end
        if (rgb !== 24'h0) begin errors++; $display("FAIL arst_rgb: got %h expected 000000", rgb); end
        if (invalidData !== 1'b1) begin errors++; $display("FAIL arst_invalid: got %b expected 1", invalidData); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL arst_underrun: got %b expected 0", underrun); end
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            idx_valid    = ($urandom_range(99) < 70);
            idx_data     = 8'($urandom);
            rgbRequest   = ($urandom_range(99) < 60);
            pal_we       = ($urandom_range(99) < 10);
            pal_addr     = 8'($urandom);
            pal_wdata    = 24'($urandom);
            clear_status = ($urandom_range(99) < 5);
            flush        = ($urandom_range(99) < 2);
            tick();
            checks += 6;
            if (rgb !== m_rgb) begin errors++; $display("FAIL rand_rgb_c%0d: got %h expected %h", c, rgb, m_rgb); end
            if (invalidData !== !m_valid) begin errors++; $display("FAIL rand_invalid_c%0d: got %b expected %b", c, invalidData, !m_valid); end
            if (fifo_level !== 5'(mq.size())) begin errors++; $display("FAIL rand_level_c%0d: got %0d expected %0d", c, fifo_level, mq.size()); end
            if (idx_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_idx_ready_c%0d: got %b expected %b", c, idx_ready, mq.size() < DEPTH); end
            if (frame_done !== m_fd) begin errors++; $display("FAIL rand_frame_done_c%0d: got %b expected %b", c, frame_done, m_fd); end
            if (underrun !== m_ur) begin errors++; $display("FAIL rand_underrun_c%0d: got %b expected %b", c, underrun, m_ur); end
        end
        idx_valid = 1'b0; rgbRequest = 1'b0; pal_we = 1'b0; clear_status = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underrun();
        test_pal_rbw();
        test_flush();
        test_frame();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
